// File: rtl/wb_stage_if.sv
// Bundle of upstream ALU/load/memory, decode scoreboard and register-file
// write-port signals around the writeback stage.
interface wb_stage_if;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_busy1;
    logic        q_busy2;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        err;

    modport slave (
        input  alu_we, alu_rd, alu_result,
        input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        input  mem_rvalid, mem_rdata, q_a1, q_a2,
        output alu_ready, ld_ready, q_busy1, q_busy2,
        output rf_we, rf_a3, rf_wd3, err
    );

    modport master (
        output alu_we, alu_rd, alu_result,
        output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        output mem_rvalid, mem_rdata, q_a1, q_a2,
        input  alu_ready, ld_ready, q_busy1, q_busy2,
        input  rf_we, rf_a3, rf_wd3, err
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results with in-order load responses into the
// register-file write port and tracks outstanding loads for decode stalls.
module wb_stage #(
    parameter int unsigned LDQ_DEPTH = 2,
    parameter int unsigned XLEN      = 32
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   bus
);
    localparam int unsigned PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LDQ_DEPTH + 1);

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } ldq_entry_t;

    ldq_entry_t             ent_q [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0]   vld_q, vld_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   rf_we_q, rf_we_d;
    logic [4:0]             rf_a3_q, rf_a3_d;
    logic [XLEN-1:0]        rf_wd3_q, rf_wd3_d;
    logic                   err_q, err_d;

    logic                   empty_c, full_c, pop_c, push_c, fmt_ok_c;
    logic                   busy1_c, busy2_c;
    ldq_entry_t             head_c;
    logic [XLEN-1:0]        ld_data_c;

    // Extract and extend the addressed byte/half according to funct3.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                             input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = w;
        endcase
    endfunction

    assign empty_c   = (count_q == CNT_W'(0));
    assign full_c    = (count_q == CNT_W'(LDQ_DEPTH));
    assign pop_c     = bus.mem_rvalid && !empty_c;
    assign push_c    = bus.ld_issue && !full_c;
    assign head_c    = ent_q[head_q];
    assign ld_data_c = fmt_load(head_c.funct3, head_c.addr_lo, bus.mem_rdata);
    assign fmt_ok_c  = (head_c.funct3 == 3'b000) || (head_c.funct3 == 3'b001) ||
                       (head_c.funct3 == 3'b010) || (head_c.funct3 == 3'b100) ||
                       (head_c.funct3 == 3'b101);

    // Scoreboard: includes the head being popped, whose write lands next cycle.
    always_comb begin
        busy1_c = 1'b0;
        busy2_c = 1'b0;
        for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
            if (vld_q[PTR_W'(i)] && (ent_q[PTR_W'(i)].rd == bus.q_a1) && (bus.q_a1 != 5'd0))
                busy1_c = 1'b1;
            if (vld_q[PTR_W'(i)] && (ent_q[PTR_W'(i)].rd == bus.q_a2) && (bus.q_a2 != 5'd0))
                busy2_c = 1'b1;
        end
    end

    always_comb begin
        vld_d    = vld_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rf_we_d  = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd3_d = rf_wd3_q;
        err_d    = err_q;

        if (pop_c) begin
            rf_we_d         = (head_c.rd != 5'd0);
            rf_a3_d         = head_c.rd;
            rf_wd3_d        = ld_data_c;
            vld_d[head_q]   = 1'b0;
            head_d          = head_q + PTR_W'(1);
            if (!fmt_ok_c) err_d = 1'b1;
        end else if (bus.alu_we) begin
            rf_we_d  = (bus.alu_rd != 5'd0);
            rf_a3_d  = bus.alu_rd;
            rf_wd3_d = bus.alu_result;
        end

        if (push_c) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.ld_issue && full_c)    err_d = 1'b1;
        if (bus.mem_rvalid && empty_c) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rf_we_q  <= 1'b0;
            rf_a3_q  <= 5'd0;
            rf_wd3_q <= '0;
            err_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rf_we_q  <= rf_we_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
            err_q    <= err_d;
        end
    end

    // Entry payloads are qualified by vld_q, so only the written slot changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LDQ_DEPTH; i++) ent_q[PTR_W'(i)] <= '0;
        end else if (push_c) begin
            ent_q[tail_q] <= '{rd: bus.ld_rd, funct3: bus.ld_funct3, addr_lo: bus.ld_addr_lo};
        end
    end

    assign bus.alu_ready = !pop_c;
    assign bus.ld_ready  = !full_c;
    assign bus.q_busy1   = busy1_c;
    assign bus.q_busy2   = busy2_c;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_a3     = rf_a3_q;
    assign bus.rf_wd3    = rf_wd3_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register-file writes are queued by the
// stimulus and popped by a negedge monitor; status outputs are checked inline.
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;
    exp_t exp_q[$];

    wb_stage_if bus();

    wb_stage #(.LDQ_DEPTH(2), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
        exp_t e;
        e.rd = rd;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Issue one load, answer it the next cycle and let the write drain.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] rdata, input logic [31:0] exp_wd);
        bus.ld_issue = 1'b1; bus.ld_rd = rd; bus.ld_funct3 = f3; bus.ld_addr_lo = lo;
        tick();
        bus.ld_issue = 1'b0;
        bus.q_a1 = rd;
        #1;
        check("busy_pending", 32'(bus.q_busy1), 32'(rd != 5'd0));
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
        if (rd != 5'd0) expect_wr(rd, exp_wd);
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        check("busy_cleared", 32'(bus.q_busy1), 32'd0);
        tick();
    endtask

    // Monitor: every register-file write must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_rd", 32'(bus.rf_a3), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_rd", 32'(bus.rf_a3), 32'(e.rd));
                    check("wr_data", bus.rf_wd3, e.wd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.alu_we = 1'b0; bus.alu_rd = 5'd0; bus.alu_result = 32'd0;
        bus.ld_issue = 1'b0; bus.ld_rd = 5'd0; bus.ld_funct3 = 3'd0; bus.ld_addr_lo = 2'd0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0; bus.q_a1 = 5'd3; bus.q_a2 = 5'd4;
        repeat (3) tick();
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_a3", 32'(bus.rf_a3), 32'd0);
        check("rst_rf_wd3", bus.rf_wd3, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_busy1", 32'(bus.q_busy1), 32'd0);
        reset = 1'b0;
        tick();

        // ALU write, single-cycle pulse on rf_we
        bus.alu_we = 1'b1; bus.alu_rd = 5'd5; bus.alu_result = 32'h0000_1234;
        #1;
        check("alu_ready_idle", 32'(bus.alu_ready), 32'd1);
        expect_wr(5'd5, 32'h0000_1234);
        tick();
        bus.alu_we = 1'b0;
        check("alu_rf_we_n1", 32'(bus.rf_we), 32'd1);
        tick();
        check("alu_rf_we_n2", 32'(bus.rf_we), 32'd0);

        // Load formatting
        do_load(5'd3, 3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
        do_load(5'd3, 3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080);
        do_load(5'd3, 3'b101, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF);
        do_load(5'd8, 3'b001, 2'd1, 32'h0000_8001, 32'hFFFF_8001);
        do_load(5'd8, 3'b010, 2'd3, 32'h1234_5678, 32'h1234_5678);
        do_load(5'd8, 3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F);
        check("fmt_err_clear", 32'(bus.err), 32'd0);

        // Load response beats a simultaneous ALU result
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd6; bus.ld_funct3 = 3'b010; bus.ld_addr_lo = 2'd0;
        tick();
        bus.ld_issue = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        bus.alu_we = 1'b1; bus.alu_rd = 5'd9; bus.alu_result = 32'h0000_0099;
        #1;
        check("arb_alu_ready_lo", 32'(bus.alu_ready), 32'd0);
        expect_wr(5'd6, 32'hCAFE_F00D);
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        check("arb_alu_ready_hi", 32'(bus.alu_ready), 32'd1);
        expect_wr(5'd9, 32'h0000_0099);
        tick();
        bus.alu_we = 1'b0;
        tick();

        // Destination x0: consumed but never written
        bus.alu_we = 1'b1; bus.alu_rd = 5'd0; bus.alu_result = 32'h5555_5555;
        tick();
        bus.alu_we = 1'b0;
        check("x0_alu_no_we", 32'(bus.rf_we), 32'd0);
        tick();
        do_load(5'd0, 3'b010, 2'd0, 32'hFFFF_FFFF, 32'd0);
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd10; bus.ld_funct3 = 3'b010;
        tick();
        bus.ld_issue = 1'b0;
        #1;
        check("x0_popped_ld_ready", 32'(bus.ld_ready), 32'd1);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_000A;
        expect_wr(5'd10, 32'h0000_000A);
        tick();
        bus.mem_rvalid = 1'b0;
        tick();
        check("x0_err_clear", 32'(bus.err), 32'd0);

        // Unsupported funct3: raw word written, error flagged
        do_load(5'd12, 3'b011, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("bad_f3_err", 32'(bus.err), 32'd1);
        pulse_reset();
        check("err_cleared_by_reset", 32'(bus.err), 32'd0);

        // Response with nothing outstanding
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        check("rvalid_empty_err", 32'(bus.err), 32'd1);
        check("rvalid_empty_no_we", 32'(bus.rf_we), 32'd0);
        pulse_reset();

        // Full queue, dropped issue, in-order responses
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd4; bus.ld_funct3 = 3'b010; bus.ld_addr_lo = 2'd0;
        tick();
        bus.ld_rd = 5'd7; bus.ld_funct3 = 3'b100; bus.ld_addr_lo = 2'd1;
        tick();
        bus.ld_issue = 1'b0; bus.q_a1 = 5'd7; bus.q_a2 = 5'd4;
        #1;
        check("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("full_busy1_x7", 32'(bus.q_busy1), 32'd1);
        check("full_busy2_x4", 32'(bus.q_busy2), 32'd1);
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd9;
        tick();
        bus.ld_issue = 1'b0; bus.q_a2 = 5'd9;
        #1;
        check("drop_err", 32'(bus.err), 32'd1);
        check("drop_not_queued", 32'(bus.q_busy2), 32'd0);
        check("drop_still_full", 32'(bus.ld_ready), 32'd0);
        bus.q_a2 = 5'd4;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_1111;
        expect_wr(5'd4, 32'h1111_1111);
        #1;
        check("pop_head_still_busy", 32'(bus.q_busy2), 32'd1);
        tick();
        bus.mem_rdata = 32'h0000_AB00;
        expect_wr(5'd7, 32'h0000_00AB);
        #1;
        check("after_pop1_busy2", 32'(bus.q_busy2), 32'd0);
        check("after_pop1_busy1", 32'(bus.q_busy1), 32'd1);
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        check("after_pop2_busy1", 32'(bus.q_busy1), 32'd0);
        check("after_pop2_ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();

        // Reset with two loads pending discards them
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd10; bus.ld_funct3 = 3'b010;
        tick();
        bus.ld_rd = 5'd11;
        tick();
        bus.ld_issue = 1'b0; bus.q_a1 = 5'd10; bus.q_a2 = 5'd11;
        #1;
        check("pre_rst_full", 32'(bus.ld_ready), 32'd0);
        pulse_reset();
        check("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("mid_rst_busy1", 32'(bus.q_busy1), 32'd0);
        check("mid_rst_busy2", 32'(bus.q_busy2), 32'd0);
        check("mid_rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3333_3333;
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        check("mid_rst_queue_empty_err", 32'(bus.err), 32'd1);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
